// File: rtl/ibex_avalon_bridge_pipelined.sv
// Bridges the ibex data port (req/gnt/rvalid) onto a pipelined Avalon-MM master.
// Up to MAX_OUTSTANDING reads are in flight; writes wait for reads to drain so responses stay in order.
module ibex_avalon_bridge_pipelined #(
  parameter int DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  localparam int BE_W           = DATA_WIDTH / 8,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  data_req_i,
  input  logic                  data_we_i,
  input  logic [BE_W-1:0]       data_be_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [DATA_WIDTH-1:0] data_rdata_o,
  output logic                  data_err_o,
  output logic [ADDR_WIDTH-1:0] avm_main_address,
  output logic [BE_W-1:0]       avm_main_byteenable,
  output logic                  avm_main_read,
  output logic                  avm_main_write,
  output logic [DATA_WIDTH-1:0] avm_main_writedata,
  input  logic                  avm_main_waitrequest,
  input  logic [DATA_WIDTH-1:0] avm_main_readdata,
  input  logic                  avm_main_readdatavalid,
  input  logic [1:0]            avm_main_response,
  output logic [CNT_W-1:0]      outstanding_o,
  output logic                  protocol_err_o
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~(ADDR_WIDTH'(BE_W - 1));
  localparam logic [CNT_W-1:0]      CNT_MAX   = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
  logic                  rvalid_q, rvalid_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  perr_q, perr_d;

  logic can_rd, can_wr;
  logic rd_accept, wr_accept, rd_return, stray_return;

  assign can_rd = (rd_cnt_q < CNT_MAX);
  assign can_wr = (rd_cnt_q == '0);

  assign avm_main_read       = data_req_i & ~data_we_i & can_rd;
  assign avm_main_write      = data_req_i &  data_we_i & can_wr;
  assign avm_main_address    = data_addr_i & ADDR_MASK;
  assign avm_main_byteenable = data_be_i;
  assign avm_main_writedata  = data_wdata_i;

  assign data_gnt_o = (avm_main_read | avm_main_write) & ~avm_main_waitrequest;

  assign rd_accept    = avm_main_read  & ~avm_main_waitrequest;
  assign wr_accept    = avm_main_write & ~avm_main_waitrequest;
  assign rd_return    = avm_main_readdatavalid & (rd_cnt_q != '0);
  // Data arriving with nothing outstanding has no owner; drop it and flag the interconnect.
  assign stray_return = avm_main_readdatavalid & (rd_cnt_q == '0);

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    case ({rd_accept, rd_return})
      2'b10:   rd_cnt_d = rd_cnt_q + CNT_W'(1);
      2'b01:   rd_cnt_d = rd_cnt_q - CNT_W'(1);
      default: rd_cnt_d = rd_cnt_q;
    endcase
  end

  always_comb begin
    rvalid_d = rd_return | wr_accept;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    perr_d   = perr_q | stray_return;
    if (rd_return) begin
      rdata_d = avm_main_readdata;
      err_d   = (avm_main_response != 2'b00);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_cnt_q <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      perr_q   <= 1'b0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      perr_q   <= perr_d;
    end
  end

  assign data_rvalid_o  = rvalid_q;
  assign data_err_o     = err_q;
  assign data_rdata_o   = rdata_q;
  assign outstanding_o  = rd_cnt_q;
  assign protocol_err_o = perr_q;

endmodule

// File: tb/tb_ibex_avalon_bridge_pipelined.sv
// Directed bench for ibex_avalon_bridge_pipelined with default parameters (64-bit data, 4 outstanding).
module tb_ibex_avalon_bridge_pipelined;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we;
  logic [7:0]  be;
  logic [31:0] addr;
  logic [63:0] wdata;
  logic        gnt, rvalid, err;
  logic [63:0] rdata;
  logic [31:0] av_addr;
  logic [7:0]  av_be;
  logic        av_rd, av_wr;
  logic [63:0] av_wdata;
  logic        waitreq;
  logic [63:0] readdata;
  logic        rdv;
  logic [1:0]  resp;
  logic [2:0]  outst;
  logic        perr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ibex_avalon_bridge_pipelined dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .data_req_i             (req),
    .data_we_i              (we),
    .data_be_i              (be),
    .data_addr_i            (addr),
    .data_wdata_i           (wdata),
    .data_gnt_o             (gnt),
    .data_rvalid_o          (rvalid),
    .data_rdata_o           (rdata),
    .data_err_o             (err),
    .avm_main_address       (av_addr),
    .avm_main_byteenable    (av_be),
    .avm_main_read          (av_rd),
    .avm_main_write         (av_wr),
    .avm_main_writedata     (av_wdata),
    .avm_main_waitrequest   (waitreq),
    .avm_main_readdata      (readdata),
    .avm_main_readdatavalid (rdv),
    .avm_main_response      (resp),
    .outstanding_o          (outst),
    .protocol_err_o         (perr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Move to the falling edge, where outputs are sampled.
  task automatic mid();
    @(negedge clk);
  endtask

  task automatic rd_req(input logic [31:0] a);
    req = 1'b1; we = 1'b0; addr = a; be = 8'hFF;
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0;
    waitreq = 1'b0; readdata = '0; rdv = 1'b0; resp = 2'b00;
    cyc(); cyc();
    rst = 1'b0;
    mid();
    chk("rst_outst", 64'(outst), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_perr", 64'(perr), 64'd0);
    chk("rst_gnt", 64'(gnt), 64'd0);
    cyc();

    // 1: single read, slave latency 2
    rd_req(32'h0000_1004);
    mid();
    chk("t1_addr", 64'(av_addr), 64'h1000);
    chk("t1_read", 64'(av_rd), 64'd1);
    chk("t1_gnt", 64'(gnt), 64'd1);
    cyc(); req = 1'b0;
    mid();
    chk("t1_outst", 64'(outst), 64'd1);
    cyc(); rdv = 1'b1; readdata = 64'hDEADBEEF_CAFEF00D;
    mid();
    chk("t1_rv_early", 64'(rvalid), 64'd0);
    cyc(); rdv = 1'b0;
    mid();
    chk("t1_rvalid", 64'(rvalid), 64'd1);
    chk("t1_rdata", rdata, 64'hDEADBEEF_CAFEF00D);
    chk("t1_err", 64'(err), 64'd0);
    chk("t1_outst0", 64'(outst), 64'd0);
    cyc();
    mid();
    chk("t1_pulse", 64'(rvalid), 64'd0);
    cyc();

    // 2: pipelined reads up to the outstanding limit
    for (int i = 0; i < 4; i++) begin
      rd_req(32'h100 + 32'(i * 8));
      mid();
      chk($sformatf("t2_gnt%0d", i), 64'(gnt), 64'd1);
      cyc();
    end
    rd_req(32'h200);
    mid();
    chk("t2_gnt_full", 64'(gnt), 64'd0);
    chk("t2_rd_full", 64'(av_rd), 64'd0);
    chk("t2_outst4", 64'(outst), 64'd4);
    cyc(); rdv = 1'b1; readdata = 64'h1;
    mid();
    chk("t2_gnt_ret", 64'(gnt), 64'd0);
    cyc(); rdv = 1'b0;
    mid();
    chk("t2_rvalid", 64'(rvalid), 64'd1);
    chk("t2_outst3", 64'(outst), 64'd3);
    chk("t2_gnt5", 64'(gnt), 64'd1);
    cyc(); req = 1'b0;
    mid();
    chk("t2_outst_back", 64'(outst), 64'd4);
    cyc();
    rdv = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    rdv = 1'b0;
    mid();
    chk("t2_drained", 64'(outst), 64'd0);
    chk("t2_perr", 64'(perr), 64'd0);
    cyc();

    // 3: write waits for two outstanding reads
    rd_req(32'h400); cyc();
    rd_req(32'h408); cyc();
    req = 1'b1; we = 1'b1; addr = 32'h2008; be = 8'hF0; wdata = 64'h5555_AAAA_0000_FFFF;
    mid();
    chk("t3_gnt_w0", 64'(gnt), 64'd0);
    chk("t3_wr_w0", 64'(av_wr), 64'd0);
    cyc(); rdv = 1'b1; readdata = 64'h11;
    mid();
    chk("t3_gnt_w1", 64'(gnt), 64'd0);
    cyc(); readdata = 64'h22;
    mid();
    chk("t3_rv1", 64'(rvalid), 64'd1);
    chk("t3_rd1", rdata, 64'h11);
    chk("t3_gnt_w2", 64'(gnt), 64'd0);
    cyc(); rdv = 1'b0;
    mid();
    chk("t3_rv2", 64'(rvalid), 64'd1);
    chk("t3_rd2", rdata, 64'h22);
    chk("t3_wr", 64'(av_wr), 64'd1);
    chk("t3_gnt_w", 64'(gnt), 64'd1);
    cyc(); req = 1'b0; we = 1'b0;
    mid();
    chk("t3_rvw", 64'(rvalid), 64'd1);
    chk("t3_errw", 64'(err), 64'd0);
    chk("t3_rdata_hold", rdata, 64'h22);
    cyc();
    mid();
    chk("t3_pulse", 64'(rvalid), 64'd0);
    cyc();

    // 4: write stalled by waitrequest for 3 cycles
    req = 1'b1; we = 1'b1; addr = 32'h3005; be = 8'h0F; wdata = 64'h0123_4567_89AB_CDEF;
    waitreq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk($sformatf("t4_wr%0d", i), 64'(av_wr), 64'd1);
      chk($sformatf("t4_addr%0d", i), 64'(av_addr), 64'h3000);
      chk($sformatf("t4_be%0d", i), 64'(av_be), 64'h0F);
      chk($sformatf("t4_wd%0d", i), av_wdata, 64'h0123_4567_89AB_CDEF);
      chk($sformatf("t4_gnt%0d", i), 64'(gnt), 64'd0);
      chk($sformatf("t4_rv%0d", i), 64'(rvalid), 64'd0);
      cyc();
    end
    waitreq = 1'b0;
    mid();
    chk("t4_gnt", 64'(gnt), 64'd1);
    cyc(); req = 1'b0; we = 1'b0;
    mid();
    chk("t4_rv", 64'(rvalid), 64'd1);
    chk("t4_err", 64'(err), 64'd0);
    cyc();

    // 5: error response mapping
    rd_req(32'h500); cyc();
    rd_req(32'h508); cyc();
    rd_req(32'h510); cyc();
    req = 1'b0;
    rdv = 1'b1; readdata = 64'hA1; resp = 2'b10;
    cyc(); readdata = 64'hA2; resp = 2'b11;
    mid();
    chk("t5_rv1", 64'(rvalid), 64'd1);
    chk("t5_err1", 64'(err), 64'd1);
    chk("t5_rd1", rdata, 64'hA1);
    cyc(); readdata = 64'hA3; resp = 2'b00;
    mid();
    chk("t5_rv2", 64'(rvalid), 64'd1);
    chk("t5_err2", 64'(err), 64'd1);
    cyc(); rdv = 1'b0;
    mid();
    chk("t5_rv3", 64'(rvalid), 64'd1);
    chk("t5_err3", 64'(err), 64'd0);
    chk("t5_rd3", rdata, 64'hA3);
    chk("t5_outst", 64'(outst), 64'd0);
    cyc();

    // 6: stray readdatavalid, then reset with reads in flight
    rdv = 1'b1; readdata = 64'hBAD;
    cyc(); rdv = 1'b0;
    mid();
    chk("t6_no_rv", 64'(rvalid), 64'd0);
    chk("t6_perr", 64'(perr), 64'd1);
    chk("t6_rdata_kept", rdata, 64'hA3);
    cyc(); cyc();
    mid();
    chk("t6_perr_sticky", 64'(perr), 64'd1);
    cyc();
    rd_req(32'h600); cyc();
    rd_req(32'h608); cyc();
    rd_req(32'h610); cyc();
    req = 1'b0;
    mid();
    chk("t6_outst3", 64'(outst), 64'd3);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    mid();
    chk("t6_rst_outst", 64'(outst), 64'd0);
    chk("t6_rst_perr", 64'(perr), 64'd0);
    chk("t6_rst_rv", 64'(rvalid), 64'd0);
    chk("t6_rst_rdata", rdata, 64'd0);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
